// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Read hits resolve combinationally; misses walk WRITEBACK/FETCH/UPDATE against multi-cycle memory.
module dcache_controller #(
    parameter int unsigned NBLOCKS     = 8,
    parameter int unsigned BLOCK_BYTES = 4
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  READ,
    input  logic                                  WRITE,
    input  logic [7:0]                            ADDRESS,
    input  logic [7:0]                            WRITEDATA,
    output logic [7:0]                            READDATA,
    output logic                                  BUSYWAIT,
    output logic                                  MEM_READ,
    output logic                                  MEM_WRITE,
    output logic [7-$clog2(BLOCK_BYTES):0]        MEM_ADDRESS,
    output logic [8*BLOCK_BYTES-1:0]              MEM_WRITEDATA,
    input  logic [8*BLOCK_BYTES-1:0]              MEM_READDATA,
    input  logic                                  MEM_BUSYWAIT
);

    localparam int unsigned IdxW = $clog2(NBLOCKS);
    localparam int unsigned OffW = $clog2(BLOCK_BYTES);
    localparam int unsigned TagW = 8 - IdxW - OffW;
    localparam int unsigned BlkW = 8 * BLOCK_BYTES;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StFetch,
        StUpdate
    } state_e;

    state_e state_q, state_d;

    logic [NBLOCKS-1:0] valid_q, valid_d;
    logic [NBLOCKS-1:0] dirty_q, dirty_d;
    logic [TagW-1:0]    tag_q  [NBLOCKS];
    logic [BlkW-1:0]    data_q [NBLOCKS];
    logic [7:0]         readdata_q, readdata_d;

    logic [TagW-1:0] addr_tag;
    logic [IdxW-1:0] addr_idx;
    logic [OffW-1:0] addr_off;
    logic [BlkW-1:0] blk;
    logic [7:0]      sel_byte;
    logic            hit;
    logic            req;
    logic            is_rd;
    logic            line_dirty;

    logic            data_we;
    logic            tag_we;
    logic [BlkW-1:0] data_wdata;

    assign addr_tag   = ADDRESS[7 -: TagW];
    assign addr_idx   = ADDRESS[OffW +: IdxW];
    assign addr_off   = ADDRESS[OffW-1:0];
    assign blk        = data_q[addr_idx];
    assign sel_byte   = blk[{addr_off, 3'b000} +: 8];
    assign hit        = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign req        = READ | WRITE;
    // A simultaneous READ and WRITE is a store.
    assign is_rd      = READ & ~WRITE;
    assign line_dirty = valid_q[addr_idx] & dirty_q[addr_idx];

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req && !hit) begin
                    state_d = line_dirty ? StWriteback : StFetch;
                end
            end
            StWriteback: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        unique case (state_q)
            StWriteback: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[addr_idx], addr_idx};
                MEM_WRITEDATA = blk;
            end
            StFetch: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {addr_tag, addr_idx};
            end
            default: ;
        endcase
        // Gated by RESET so the stall drops asynchronously even if a request is held.
        BUSYWAIT   = RESET && ((state_q != StIdle) || (req && !hit));
        readdata_d = readdata_q;
        if ((state_q == StIdle) && is_rd && hit) begin
            readdata_d = sel_byte;
        end
        READDATA = readdata_d;
    end

    // Storage update: store hits in IDLE, line refill on leaving UPDATE
    always_comb begin
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        data_wdata = blk;
        if ((state_q == StIdle) && WRITE && hit) begin
            data_we                              = 1'b1;
            data_wdata[{addr_off, 3'b000} +: 8] = WRITEDATA;
            dirty_d[addr_idx]                    = 1'b1;
        end else if (state_q == StUpdate) begin
            data_we           = 1'b1;
            tag_we            = 1'b1;
            data_wdata        = MEM_READDATA;
            valid_d[addr_idx] = 1'b1;
            dirty_d[addr_idx] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            readdata_q <= '0;
        end else begin
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            readdata_q <= readdata_d;
        end
    end

    // Tags and data are qualified by valid, so they need no reset.
    always_ff @(posedge CLK) begin
        if (data_we) begin
            data_q[addr_idx] <= data_wdata;
        end
        if (tag_we) begin
            tag_q[addr_idx] <= addr_tag;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized self-checking bench for dcache_controller against a behavioural cache/memory model.
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    dcache_controller #(
        .NBLOCKS     (8),
        .BLOCK_BYTES (4)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: backing memory and cache contents
    logic [31:0] ref_mem   [64];
    logic        ref_valid [8];
    logic        ref_dirty [8];
    logic [2:0]  ref_tag   [8];
    logic [31:0] ref_data  [8];
    logic [7:0]  last_rd;

    // Memory environment: each request lasts mem_lat cycles, busy for all but the last.
    int          mem_lat = 5;
    int          mem_cnt;
    logic        mem_done;
    logic [31:0] mem_rdata;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && !mem_done;
    assign MEM_READDATA = mem_rdata;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_cnt   <= 0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
        end else if (mem_done) begin
            mem_done <= 1'b0;
            mem_cnt  <= 0;
        end else if (MEM_READ | MEM_WRITE) begin
            if (mem_cnt >= mem_lat - 2) begin
                mem_done <= 1'b1;
                if (MEM_READ) mem_rdata <= ref_mem[MEM_ADDRESS];
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    task automatic model_invalidate();
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        last_rd = 8'h00;
    endtask

    // One CPU access, held until the stall clears, then checked against the model.
    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd);
        logic [2:0]  idx;
        logic [2:0]  tg;
        logic [1:0]  off;
        logic        hit;
        logic        dirty;
        logic [5:0]  wb_addr;
        logic [31:0] wb_data;
        logic [5:0]  f_addr;
        logic        saw_wb;
        logic        saw_f;
        logic [7:0]  exp_rd;
        int          stall;
        idx     = addr[4:2];
        tg      = addr[7:5];
        off     = addr[1:0];
        hit     = ref_valid[idx] && (ref_tag[idx] == tg);
        dirty   = !hit && ref_valid[idx] && ref_dirty[idx];
        wb_addr = {ref_tag[idx], idx};
        wb_data = ref_data[idx];
        f_addr  = {tg, idx};
        @(negedge CLK);
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = addr;
        WRITEDATA = wd;
        #1;
        check_eq("busy_first", {31'd0, BUSYWAIT}, {31'd0, !hit});
        if (!hit) begin
            stall  = 0;
            saw_wb = 1'b0;
            saw_f  = 1'b0;
            while (BUSYWAIT === 1'b1 && stall < 200) begin
                check_eq("mem_excl", {31'd0, MEM_READ & MEM_WRITE}, 32'd0);
                if (MEM_WRITE && !saw_wb) begin
                    saw_wb = 1'b1;
                    check_eq("wb_addr", {26'd0, MEM_ADDRESS}, {26'd0, wb_addr});
                    check_eq("wb_data", MEM_WRITEDATA, wb_data);
                    check_eq("wb_before_fetch", {31'd0, saw_f}, 32'd0);
                end
                if (MEM_READ && !saw_f) begin
                    saw_f = 1'b1;
                    check_eq("fetch_addr", {26'd0, MEM_ADDRESS}, {26'd0, f_addr});
                end
                stall++;
                @(negedge CLK);
                #1;
            end
            check_eq("stall_cycles", stall, dirty ? 2 + 2 * mem_lat : 2 + mem_lat);
            check_eq("saw_wb", {31'd0, saw_wb}, {31'd0, dirty});
            check_eq("saw_fetch", {31'd0, saw_f}, 32'd1);
            if (dirty) ref_mem[wb_addr] = wb_data;
            ref_data[idx]  = ref_mem[f_addr];
            ref_tag[idx]   = tg;
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
        end
        check_eq("idle_no_req", {31'd0, MEM_READ | MEM_WRITE}, 32'd0);
        if (rd && !wr) begin
            exp_rd  = ref_data[idx][{off, 3'b000} +: 8];
            check_eq("readdata", {24'd0, READDATA}, {24'd0, exp_rd});
            last_rd = exp_rd;
        end
        if (wr) begin
            ref_data[idx][{off, 3'b000} +: 8] = wd;
            ref_dirty[idx] = 1'b1;
        end
        @(posedge CLK);
    endtask

    task automatic idle_cycle();
        logic [7:0] a;
        a = 8'($urandom);
        @(negedge CLK);
        READ    = 1'b0;
        WRITE   = 1'b0;
        ADDRESS = a;
        #1;
        check_eq("idle_busy", {31'd0, BUSYWAIT}, 32'd0);
        check_eq("idle_hold", {24'd0, READDATA}, {24'd0, last_rd});
        @(posedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        logic [2:0] tg;
        int         kind;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        ref_mem[1] = 32'hDDCC_BBAA;
        model_invalidate();
        RESET     = 1'b0;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = 8'h00;
        WRITEDATA = 8'h00;
        repeat (2) @(negedge CLK);
        #1;
        check_eq("rst_busy", {31'd0, BUSYWAIT}, 32'd0);
        check_eq("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
        check_eq("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        check_eq("rst_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
        check_eq("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
        check_eq("rst_readdata", {24'd0, READDATA}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Directed sequence
        mem_lat = 5;
        access(1'b1, 1'b0, 8'h05, 8'h00);
        check_eq("cold_bb", {24'd0, READDATA}, 32'h0000_00BB);
        access(1'b1, 1'b0, 8'h05, 8'h00);
        access(1'b1, 1'b0, 8'h06, 8'h00);
        access(1'b0, 1'b1, 8'h07, 8'h5A);
        access(1'b1, 1'b0, 8'h07, 8'h00);
        access(1'b1, 1'b0, 8'h27, 8'h00);
        access(1'b0, 1'b1, 8'h40, 8'h11);
        access(1'b1, 1'b0, 8'h40, 8'h00);
        idle_cycle();
        access(1'b1, 1'b0, 8'h00, 8'h00);
        access(1'b1, 1'b1, 8'h01, 8'hC3);
        access(1'b1, 1'b0, 8'h01, 8'h00);

        // Reset in the middle of a fetch
        @(negedge CLK);
        READ    = 1'b1;
        WRITE   = 1'b0;
        ADDRESS = 8'h85;
        repeat (3) @(negedge CLK);
        #1;
        check_eq("midrst_fetching", {31'd0, MEM_READ}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        check_eq("midrst_mem_read", {31'd0, MEM_READ}, 32'd0);
        check_eq("midrst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        check_eq("midrst_busy", {31'd0, BUSYWAIT}, 32'd0);
        READ = 1'b0;
        model_invalidate();
        @(negedge CLK);
        RESET = 1'b1;
        access(1'b1, 1'b0, 8'h05, 8'h00);

        // Randomized phase, narrow tag range to mix hits, conflicts and dirty evictions
        for (int n = 0; n < 250; n++) begin
            mem_lat = $urandom_range(2, 6);
            kind    = $urandom_range(0, 9);
            tg      = 3'($urandom_range(0, 3));
            a       = 8'($urandom);
            a[7:5]  = tg;
            d       = 8'($urandom);
            if (kind == 0) idle_cycle();
            else if (kind <= 5) access(1'b1, 1'b0, a, d);
            else if (kind <= 8) access(1'b0, 1'b1, a, d);
            else access(1'b1, 1'b1, a, d);
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
